// File: rtl/pwm_gen_if.sv
// Request/response and pin bundle between the PID controller, pwm_gen and the motor driver.
// master = controller side (drives requests), slave = pwm_gen.
interface pwm_gen_if;
    logic       pwm_enable;
    logic       pwm_update;
    logic [7:0] pwm_ratio;
    logic       pwm_direction;
    logic       pwm_done;
    logic       pwm_out;
    logic       pwm_dir_out;
    logic       period_start;

    modport master (
        output pwm_enable, pwm_update, pwm_ratio, pwm_direction,
        input  pwm_done, pwm_out, pwm_dir_out, period_start
    );

    modport slave (
        input  pwm_enable, pwm_update, pwm_ratio, pwm_direction,
        output pwm_done, pwm_out, pwm_dir_out, period_start
    );
endinterface

// File: rtl/pwm_gen.sv
// Double-buffered PWM generator: new ratios take effect on period boundaries, and a
// direction reversal is preceded by DEADTIME_PERIODS periods of coasting (output low).
module pwm_gen #(
    parameter int PRESCALE_DIV     = 4,
    parameter int DEADTIME_PERIODS = 2
) (
    input logic     clock,
    input logic     reset,
    pwm_gen_if.slave bus
);
    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam int CW = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;
    localparam logic [PW-1:0] PS_LAST    = PW'(PRESCALE_DIV - 1);
    localparam logic [CW-1:0] COAST_LAST = CW'(DEADTIME_PERIODS - 1);

    typedef enum logic [1:0] {IDLE, RUN, COAST} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic [CW-1:0] coast_q, coast_d;
    logic [7:0]    act_ratio_q, act_ratio_d;
    logic          act_dir_q, act_dir_d;
    logic [7:0]    pend_ratio_q, pend_ratio_d;
    logic          pend_dir_q, pend_dir_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;
    logic          out_q, out_d;
    logic          dir_out_q, dir_out_d;
    logic          pstart_q, pstart_d;
    logic          tick, bnd, apply;

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        pcnt_d       = pcnt_q;
        coast_d      = coast_q;
        act_ratio_d  = act_ratio_q;
        act_dir_d    = act_dir_q;
        pend_ratio_d = pend_ratio_q;
        pend_dir_d   = pend_dir_q;
        pend_d       = pend_q;
        done_d       = 1'b0;
        out_d        = 1'b0;
        dir_out_d    = act_dir_q;
        pstart_d     = 1'b0;
        apply        = 1'b0;
        tick         = (presc_q == PS_LAST);
        bnd          = tick && (pcnt_q == 8'd254);

        case (state_q)
            IDLE: begin
                presc_d = '0;
                pcnt_d  = '0;
                // While idle there is no period to wait for, so updates go straight to active.
                if (bus.pwm_update) begin
                    act_ratio_d = bus.pwm_ratio;
                    act_dir_d   = bus.pwm_direction;
                    done_d      = 1'b1;
                end
                if (bus.pwm_enable) state_d = RUN;
            end
            default: begin
                if (!bus.pwm_enable) begin
                    state_d = IDLE;
                    presc_d = '0;
                    pcnt_d  = '0;
                    coast_d = '0;
                    pend_d  = 1'b0;
                    if (bus.pwm_update) begin
                        act_ratio_d = bus.pwm_ratio;
                        act_dir_d   = bus.pwm_direction;
                        done_d      = 1'b1;
                    end else if (pend_q) begin
                        act_ratio_d = pend_ratio_q;
                        act_dir_d   = pend_dir_q;
                        done_d      = 1'b1;
                    end
                end else begin
                    out_d    = (state_q == RUN) && (act_ratio_q > pcnt_q);
                    presc_d  = tick ? '0 : presc_q + PW'(1);
                    if (tick) pcnt_d = (pcnt_q == 8'd254) ? 8'd0 : pcnt_q + 8'd1;
                    pstart_d = bnd;
                    if (bnd && pend_q) begin
                        if (state_q == COAST) begin
                            if (coast_q == COAST_LAST) begin
                                apply   = 1'b1;
                                state_d = RUN;
                            end else begin
                                coast_d = coast_q + CW'(1);
                            end
                        end else if (pend_dir_q == act_dir_q) begin
                            apply = 1'b1;
                        end else begin
                            state_d = COAST;
                            coast_d = '0;
                        end
                    end
                    // A same-cycle update supersedes the value being applied, so done waits for it.
                    if (apply) begin
                        act_ratio_d = pend_ratio_q;
                        act_dir_d   = pend_dir_q;
                        pend_d      = 1'b0;
                        done_d      = !bus.pwm_update;
                    end
                    if (bus.pwm_update) begin
                        pend_ratio_d = bus.pwm_ratio;
                        pend_dir_d   = bus.pwm_direction;
                        pend_d       = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            pcnt_q       <= '0;
            coast_q      <= '0;
            act_ratio_q  <= '0;
            act_dir_q    <= 1'b0;
            pend_ratio_q <= '0;
            pend_dir_q   <= 1'b0;
            pend_q       <= 1'b0;
            done_q       <= 1'b0;
            out_q        <= 1'b0;
            dir_out_q    <= 1'b0;
            pstart_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            pcnt_q       <= pcnt_d;
            coast_q      <= coast_d;
            act_ratio_q  <= act_ratio_d;
            act_dir_q    <= act_dir_d;
            pend_ratio_q <= pend_ratio_d;
            pend_dir_q   <= pend_dir_d;
            pend_q       <= pend_d;
            done_q       <= done_d;
            out_q        <= out_d;
            dir_out_q    <= dir_out_d;
            pstart_q     <= pstart_d;
        end
    end

    assign bus.pwm_done     = done_q;
    assign bus.pwm_out      = out_q;
    assign bus.pwm_dir_out  = dir_out_q;
    assign bus.period_start = pstart_q;
endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: directed scenarios plus random update/enable/reset traffic,
// every cycle compared against a period-time reference model.
module tb_pwm_gen;
    localparam int P   = 4;
    localparam int DT  = 2;
    localparam int PER = 255 * P;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    pwm_gen_if bus();

    pwm_gen #(.PRESCALE_DIV(P), .DEADTIME_PERIODS(DT)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model: time within the period in clocks, periods of coast left.
    bit m_run = 0, m_ad = 0, m_pd = 0, m_pv = 0;
    int m_t = 0, m_ar = 0, m_pr = 0, m_coast = 0;
    bit e_out = 0, e_dir = 0, e_done = 0, e_ps = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic mdl_reset();
        m_run = 0; m_ad = 0; m_pd = 0; m_pv = 0;
        m_t = 0; m_ar = 0; m_pr = 0; m_coast = 0;
        e_out = 0; e_dir = 0; e_done = 0; e_ps = 0;
    endtask

    task automatic mdl_apply(input bit up);
        m_ar = m_pr; m_ad = m_pd; m_pv = 0;
        e_done = !up;
    endtask

    task automatic mdl_step();
        bit en, up, d, bnd;
        int r;
        en = bus.pwm_enable; up = bus.pwm_update; d = bus.pwm_direction; r = bus.pwm_ratio;
        e_dir = m_ad; e_out = 0; e_ps = 0; e_done = 0;
        if (!m_run) begin
            if (up) begin m_ar = r; m_ad = d; e_done = 1; end
            if (en) begin m_run = 1; m_t = 0; end
        end else if (!en) begin
            if (up) begin m_ar = r; m_ad = d; e_done = 1; end
            else if (m_pv) begin m_ar = m_pr; m_ad = m_pd; e_done = 1; end
            m_pv = 0; m_run = 0; m_coast = 0; m_t = 0;
        end else begin
            e_out = (m_coast == 0) && (m_ar > m_t / P);
            bnd   = (m_t == PER - 1);
            e_ps  = bnd;
            if (bnd && m_pv) begin
                if (m_coast > 0) begin
                    m_coast--;
                    if (m_coast == 0) mdl_apply(up);
                end else if (m_pd == m_ad) mdl_apply(up);
                else m_coast = DT;
            end
            if (up) begin m_pr = r; m_pd = d; m_pv = 1; end
            m_t = bnd ? 0 : m_t + 1;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) mdl_reset();
        else mdl_step();
    end

    always @(negedge clock) begin
        chk("pwm_out", bus.pwm_out, e_out);
        chk("pwm_dir_out", bus.pwm_dir_out, e_dir);
        chk("pwm_done", bus.pwm_done, e_done);
        chk("period_start", bus.period_start, e_ps);
    end

    task automatic cyc(input int n);
        repeat (n) begin @(negedge clock); #1; end
    endtask

    task automatic send(input int r, input bit d);
        bus.pwm_ratio = 8'(r); bus.pwm_direction = d; bus.pwm_update = 1'b1;
        cyc(1);
        bus.pwm_update = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k = 0;
        bit seen = 0;
        while (!seen && k < lim) begin
            cyc(1); k++;
            seen = bus.pwm_done;
        end
        chk(tag, seen, 1);
    endtask

    task automatic wait_ps(input string tag, input int lim);
        int k = 0;
        bit seen = 0;
        while (!seen && k < lim) begin
            cyc(1); k++;
            seen = bus.period_start;
        end
        chk(tag, seen, 1);
    endtask

    task automatic measure(output int hi, output int ps, output int dn);
        hi = 0; ps = 0; dn = 0;
        repeat (PER) begin
            cyc(1);
            hi += bus.pwm_out; ps += bus.period_start; dn += bus.pwm_done;
        end
    endtask

    int hi, ps, dn, n;

    initial begin
        bus.pwm_enable = 0; bus.pwm_update = 0; bus.pwm_ratio = 0; bus.pwm_direction = 0;
        cyc(3);
        chk("rst_out", bus.pwm_out, 0);
        chk("rst_done", bus.pwm_done, 0);
        chk("rst_dir", bus.pwm_dir_out, 0);
        chk("rst_ps", bus.period_start, 0);
        reset = 0;
        cyc(2);

        // ratio 64 applied at the first boundary
        bus.pwm_enable = 1;
        cyc(1);
        send(64, 0);
        wait_done("done_64", PER + 50);
        measure(hi, ps, dn);
        chk("high_64", hi, 64 * P);
        chk("dir_64", bus.pwm_dir_out, 0);

        // ratio 0 then 255, glitch-free across boundaries
        send(0, 0);
        wait_done("done_0", PER + 50);
        measure(hi, ps, dn);
        chk("high_0", hi, 0);
        chk("ps_per_period", ps, 1);
        send(255, 0);
        wait_done("done_255", PER + 50);
        measure(hi, ps, dn);
        chk("high_255", hi, PER);
        measure(hi, ps, dn);
        chk("high_255_span", hi, PER);

        // direction reversal with coast
        send(128, 0);
        wait_done("done_128", PER + 50);
        send(100, 1);
        wait_ps("coast_start", PER + 50);
        n = 0; hi = 0;
        while (!bus.pwm_done && n < 3 * PER) begin
            cyc(1); n++; hi += bus.pwm_out;
        end
        chk("coast_len", n, DT * PER);
        chk("coast_high", hi, 0);
        measure(hi, ps, dn);
        chk("high_100", hi, 100 * P);
        chk("dir_flip", bus.pwm_dir_out, 1);
        chk("coast_single_done", dn, 0);

        // three updates within one period -> one done
        send(10, 1); cyc(100);
        send(20, 1); cyc(100);
        send(30, 1);
        wait_done("done_30", PER + 50);
        measure(hi, ps, dn);
        chk("high_30", hi, 30 * P);
        chk("extra_done", dn, 0);

        // disabled update loads directly
        bus.pwm_enable = 0;
        cyc(5);
        bus.pwm_ratio = 8'd50; bus.pwm_direction = 0; bus.pwm_update = 1;
        cyc(1);
        bus.pwm_update = 0;
        chk("idle_done", bus.pwm_done, 1);
        cyc(1);
        chk("idle_out", bus.pwm_out, 0);
        chk("idle_dir", bus.pwm_dir_out, 0);
        send(50, 1);
        chk("idle_done2", bus.pwm_done, 1);
        cyc(1);
        chk("idle_dir2", bus.pwm_dir_out, 1);
        bus.pwm_enable = 1;
        cyc(1);
        measure(hi, ps, dn);
        chk("high_50_first", hi, 50 * P);

        // enable dropped mid-period, with a pending update applied at once
        cyc(300);
        send(70, 1);
        bus.pwm_enable = 0;
        cyc(1);
        chk("drop_out", bus.pwm_out, 0);
        chk("drop_done", bus.pwm_done, 1);
        bus.pwm_enable = 1;
        cyc(1);
        measure(hi, ps, dn);
        chk("high_70_restart", hi, 70 * P);

        // reset mid-coast
        send(80, 0);
        wait_ps("coast2_start", PER + 50);
        cyc(300);
        reset = 1;
        #1;
        chk("async_rst_out", bus.pwm_out, 0);
        chk("async_rst_dir", bus.pwm_dir_out, 0);
        cyc(3);
        reset = 0;
        measure(hi, ps, dn);
        chk("post_rst_done", dn, 0);
        chk("post_rst_high", hi, 0);

        // random traffic
        for (int i = 0; i < 40000; i++) begin
            if ($urandom_range(0, 24999) == 0) begin
                reset = 1;
                cyc($urandom_range(1, 3));
                reset = 0;
            end
            if (bus.pwm_enable) begin
                if ($urandom_range(0, 5999) == 0) bus.pwm_enable = 0;
            end else if ($urandom_range(0, 199) == 0) bus.pwm_enable = 1;
            bus.pwm_update = ($urandom_range(0, 299) == 0);
            if (bus.pwm_update) begin
                case ($urandom_range(0, 9))
                    0:       bus.pwm_ratio = 8'd0;
                    1:       bus.pwm_ratio = 8'd255;
                    default: bus.pwm_ratio = 8'($urandom_range(0, 255));
                endcase
                if ($urandom_range(0, 3) == 0) bus.pwm_direction = ~bus.pwm_direction;
            end
            cyc(1);
        end
        bus.pwm_update = 0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
